// File: rtl/sram_rr_arbiter_if.sv
// -----------------------------------------------------------------------------
// sram_rr_arbiter_if
// Bundles the two requester command/response buses and the SRAM macro pins
// that connect to sram_rr_arbiter.
//
// Signal summary
//   hold                      : stop issuing grants (in-flight work completes)
//   req_x / we_x / addr_x /
//   wdata_x                   : requester x command (x = a, b)
//   gnt_x                     : requester x command accepted this cycle
//   rvalid_x / rdata_x        : requester x read response
//   mem_addr / mem_wdata /
//   mem_cs / mem_rd / mem_wr  : registered SRAM command pins
//   mem_rdata                 : SRAM registered read data
//
// Modports
//   slave  : the arbiter's view
//   master : the environment's view (requesters plus the SRAM macro)
// -----------------------------------------------------------------------------
interface sram_rr_arbiter_if #(
    parameter int ADDR_WD = 8,
    parameter int DATA_WD = 8
);
    logic               hold;

    logic               req_a;
    logic               we_a;
    logic [ADDR_WD-1:0] addr_a;
    logic [DATA_WD-1:0] wdata_a;
    logic               gnt_a;
    logic               rvalid_a;
    logic [DATA_WD-1:0] rdata_a;

    logic               req_b;
    logic               we_b;
    logic [ADDR_WD-1:0] addr_b;
    logic [DATA_WD-1:0] wdata_b;
    logic               gnt_b;
    logic               rvalid_b;
    logic [DATA_WD-1:0] rdata_b;

    logic [ADDR_WD-1:0] mem_addr;
    logic [DATA_WD-1:0] mem_wdata;
    logic               mem_cs;
    logic               mem_rd;
    logic               mem_wr;
    logic [DATA_WD-1:0] mem_rdata;

    modport slave (
        input  hold,
        input  req_a, we_a, addr_a, wdata_a,
        output gnt_a, rvalid_a, rdata_a,
        input  req_b, we_b, addr_b, wdata_b,
        output gnt_b, rvalid_b, rdata_b,
        output mem_addr, mem_wdata, mem_cs, mem_rd, mem_wr,
        input  mem_rdata
    );

    modport master (
        output hold,
        output req_a, we_a, addr_a, wdata_a,
        input  gnt_a, rvalid_a, rdata_a,
        output req_b, we_b, addr_b, wdata_b,
        input  gnt_b, rvalid_b, rdata_b,
        input  mem_addr, mem_wdata, mem_cs, mem_rd, mem_wr,
        output mem_rdata
    );
endinterface

// File: rtl/sram_rr_arbiter.sv
// -----------------------------------------------------------------------------
// sram_rr_arbiter
// Shares one single-port synchronous SRAM between requesters A and B.
// Three-stage pipeline:
//   stage 0 : combinational round-robin grant (one command per cycle)
//   stage 1 : registered SRAM command (cs/rd/wr/addr/wdata) plus owner tag
//   stage 2 : registered rvalid to the owner; rdata is the SRAM output
// A read granted in cycle N returns rvalid in cycle N+2.
//
// Ports
//   clock : rising-edge clock
//   reset : synchronous active-high reset (flushes pipeline, pointer -> A)
//   bus   : sram_rr_arbiter_if.slave (requester buses and SRAM pins)
// -----------------------------------------------------------------------------
module sram_rr_arbiter #(
    parameter int ADDR_WD = 8,
    parameter int DATA_WD = 8
) (
    input  logic                clock,
    input  logic                reset,
    sram_rr_arbiter_if.slave    bus
);

    logic               w_gnt_a;
    logic               w_gnt_b;
    logic               w_any_gnt;
    logic               w_sel_we;
    logic [ADDR_WD-1:0] w_sel_addr;
    logic [DATA_WD-1:0] w_sel_wdata;

    // 1 = B has priority on the next contested cycle, 0 = A has priority.
    logic               r_ptr_b;
    // Stage-1 owner tag: 1 = command belongs to B.
    logic               r_own_b;
    logic               r_mem_cs;
    logic               r_mem_rd;
    logic               r_mem_wr;
    logic [ADDR_WD-1:0] r_mem_addr;
    logic [DATA_WD-1:0] r_mem_wdata;
    logic               r_rvalid_a;
    logic               r_rvalid_b;

    // Stage 0: round-robin grant; reset and hold suppress every grant.
    always_comb begin
        w_gnt_a = 1'b0;
        w_gnt_b = 1'b0;
        if (reset || bus.hold) begin
            w_gnt_a = 1'b0;
            w_gnt_b = 1'b0;
        end else if (bus.req_a && bus.req_b) begin
            if (r_ptr_b) begin
                w_gnt_b = 1'b1;
            end else begin
                w_gnt_a = 1'b1;
            end
        end else begin
            w_gnt_a = bus.req_a;
            w_gnt_b = bus.req_b;
        end
    end

    // Stage 0: select the granted requester's payload.
    always_comb begin
        w_any_gnt   = w_gnt_a | w_gnt_b;
        w_sel_we    = bus.we_a;
        w_sel_addr  = bus.addr_a;
        w_sel_wdata = bus.wdata_a;
        if (w_gnt_b) begin
            w_sel_we    = bus.we_b;
            w_sel_addr  = bus.addr_b;
            w_sel_wdata = bus.wdata_b;
        end else begin
            w_sel_we    = bus.we_a;
            w_sel_addr  = bus.addr_a;
            w_sel_wdata = bus.wdata_a;
        end
    end

    // Priority pointer: after a grant, the other requester is preferred.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_ptr_b <= 1'b0;
        end else if (w_any_gnt) begin
            r_ptr_b <= w_gnt_a;
        end else begin
            r_ptr_b <= r_ptr_b;
        end
    end

    // Stage 1: register the granted command onto the SRAM pins.
    // Address and write data keep their last values when idle so the SRAM
    // inputs do not toggle needlessly; write data changes only on writes.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_mem_cs    <= 1'b0;
            r_mem_rd    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_mem_addr  <= {ADDR_WD{1'b0}};
            r_mem_wdata <= {DATA_WD{1'b0}};
            r_own_b     <= 1'b0;
        end else if (w_any_gnt) begin
            r_mem_cs   <= 1'b1;
            r_mem_rd   <= ~w_sel_we;
            r_mem_wr   <= w_sel_we;
            r_mem_addr <= w_sel_addr;
            r_own_b    <= w_gnt_b;
            if (w_sel_we) begin
                r_mem_wdata <= w_sel_wdata;
            end else begin
                r_mem_wdata <= r_mem_wdata;
            end
        end else begin
            r_mem_cs <= 1'b0;
            r_mem_rd <= 1'b0;
            r_mem_wr <= 1'b0;
        end
    end

    // Stage 2: the SRAM captures read data at the end of stage 1, so the
    // owner's rvalid is raised in the following cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rvalid_a <= 1'b0;
            r_rvalid_b <= 1'b0;
        end else begin
            r_rvalid_a <= r_mem_cs & r_mem_rd & ~r_own_b;
            r_rvalid_b <= r_mem_cs & r_mem_rd & r_own_b;
        end
    end

    assign bus.gnt_a     = w_gnt_a;
    assign bus.gnt_b     = w_gnt_b;
    assign bus.mem_cs    = r_mem_cs;
    assign bus.mem_rd    = r_mem_rd;
    assign bus.mem_wr    = r_mem_wr;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.rvalid_a  = r_rvalid_a;
    assign bus.rvalid_b  = r_rvalid_b;
    // Both requesters see the SRAM output; only the one with rvalid uses it.
    assign bus.rdata_a   = bus.mem_rdata;
    assign bus.rdata_b   = bus.mem_rdata;

endmodule

// File: tb/tb_sram_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_rr_arbiter
// Drives directed scenarios and randomized traffic into sram_rr_arbiter, with
// a behavioural SRAM macro and a transaction-level reference model that
// predicts grants, SRAM commands and read responses cycle by cycle.
// -----------------------------------------------------------------------------
module tb_sram_rr_arbiter;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    sram_rr_arbiter_if #(.ADDR_WD(8), .DATA_WD(8)) bus ();

    sram_rr_arbiter #(.ADDR_WD(8), .DATA_WD(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // SRAM macro: synchronous write, registered read output, ignores reset.
    logic [7:0] sram [0:255];
    always @(posedge clock) begin
        if (bus.mem_cs && bus.mem_wr) sram[bus.mem_addr] <= bus.mem_wdata;
        if (bus.mem_cs && bus.mem_rd) bus.mem_rdata <= sram[bus.mem_addr];
    end

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    // Memory contents as seen by the requesters, updated when a write is granted.
    logic [7:0] ref_mem [0:255];
    int  pref;        // 0: A preferred when both request, 1: B preferred
    bit  checking = 1'b0;
    // Expectations per cycle, in a small ring indexed by cycle number.
    bit         e_cs  [4];
    bit         e_rd  [4];
    bit         e_wr  [4];
    bit         e_rva [4];
    bit         e_rvb [4];
    logic [7:0] e_addr  [4];
    logic [7:0] e_wdata [4];
    logic [7:0] e_rdata [4];

    bit         m_ga, m_gb, m_we;
    logic [7:0] m_ad, m_wd;
    int         s0, s1, s2;

    task automatic clear_slot(input int s);
        e_cs[s] = 1'b0; e_rd[s] = 1'b0; e_wr[s] = 1'b0;
        e_rva[s] = 1'b0; e_rvb[s] = 1'b0;
    endtask

    // Model step plus comparison, once per cycle away from the active edge.
    always @(negedge clock) begin
        s0 = cyc % 4; s1 = (cyc + 1) % 4; s2 = (cyc + 2) % 4;
        m_ga = 1'b0; m_gb = 1'b0;
        if (reset === 1'b1) begin
            clear_slot(s1);
            clear_slot(s2);
            pref = 0;
        end else if (bus.hold == 1'b0) begin
            if (bus.req_a && bus.req_b) begin
                if (pref == 0) m_ga = 1'b1; else m_gb = 1'b1;
            end else begin
                m_ga = bus.req_a;
                m_gb = bus.req_b;
            end
        end
        if (m_ga || m_gb) begin
            m_we = m_ga ? bus.we_a    : bus.we_b;
            m_ad = m_ga ? bus.addr_a  : bus.addr_b;
            m_wd = m_ga ? bus.wdata_a : bus.wdata_b;
            pref = m_ga ? 1 : 0;
            e_cs[s1] = 1'b1; e_rd[s1] = !m_we; e_wr[s1] = m_we;
            e_addr[s1] = m_ad; e_wdata[s1] = m_wd;
            if (m_we) begin
                ref_mem[m_ad] = m_wd;
            end else begin
                e_rva[s2] = m_ga; e_rvb[s2] = m_gb; e_rdata[s2] = ref_mem[m_ad];
            end
        end
        if (checking) begin
            chk("gnt_a", bus.gnt_a, m_ga);
            chk("gnt_b", bus.gnt_b, m_gb);
            chk("mem_cs", bus.mem_cs, e_cs[s0]);
            chk("mem_rd", bus.mem_rd, e_rd[s0]);
            chk("mem_wr", bus.mem_wr, e_wr[s0]);
            if (e_cs[s0]) chk("mem_addr", bus.mem_addr, e_addr[s0]);
            if (e_wr[s0]) chk("mem_wdata", bus.mem_wdata, e_wdata[s0]);
            chk("rvalid_a", bus.rvalid_a, e_rva[s0]);
            chk("rvalid_b", bus.rvalid_b, e_rvb[s0]);
            if (e_rva[s0]) chk("rdata_a", bus.rdata_a, e_rdata[s0]);
            if (e_rvb[s0]) chk("rdata_b", bus.rdata_b, e_rdata[s0]);
        end
        clear_slot(s0);
        if (reset === 1'b1) checking = 1'b1;
        cyc++;
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        bus.req_a = 1'b0;
        bus.req_b = 1'b0;
        bus.hold  = 1'b0;
    endtask

    task automatic cmd_a(input logic we, input logic [7:0] ad, input logic [7:0] wd);
        bus.req_a = 1'b1; bus.we_a = we; bus.addr_a = ad; bus.wdata_a = wd;
    endtask

    task automatic cmd_b(input logic we, input logic [7:0] ad, input logic [7:0] wd);
        bus.req_b = 1'b1; bus.we_b = we; bus.addr_b = ad; bus.wdata_b = wd;
    endtask

    function automatic logic [7:0] rand_addr();
        int r;
        r = $urandom_range(0, 9);
        return (r < 8) ? 8'(r) : 8'hFF;
    endfunction

    bit ga_seen, gb_seen;

    initial begin
        for (int i = 0; i < 256; i++) begin
            sram[i] = 8'h00;
            ref_mem[i] = 8'h00;
        end
        bus.mem_rdata = 8'h00;
        pref = 0;
        reset = 1'b1;
        idle();
        bus.we_a = 1'b0; bus.addr_a = 8'h00; bus.wdata_a = 8'h00;
        bus.we_b = 1'b0; bus.addr_b = 8'h00; bus.wdata_b = 8'h00;
        step(); step();
        reset = 1'b0;

        // Reset state
        @(negedge clock);
        chk("rst_mem_cs", bus.mem_cs, 1'b0);
        chk("rst_mem_rd", bus.mem_rd, 1'b0);
        chk("rst_mem_wr", bus.mem_wr, 1'b0);
        chk("rst_mem_addr", bus.mem_addr, 8'h00);
        chk("rst_mem_wdata", bus.mem_wdata, 8'h00);
        chk("rst_rvalid_a", bus.rvalid_a, 1'b0);
        chk("rst_rvalid_b", bus.rvalid_b, 1'b0);

        // Write A 0x10 = 0xA5, then read it back
        step();
        cmd_a(1'b1, 8'h10, 8'hA5);
        @(negedge clock); chk("s1_wr_gnt_a", bus.gnt_a, 1'b1);
        step();
        cmd_a(1'b0, 8'h10, 8'h00);
        @(negedge clock); chk("s1_rd_gnt_a", bus.gnt_a, 1'b1);
        step();
        idle();
        @(negedge clock); chk("s1_rvalid_a_n1", bus.rvalid_a, 1'b0);
        step();
        @(negedge clock);
        chk("s1_rvalid_a_n2", bus.rvalid_a, 1'b1);
        chk("s1_rdata_a", bus.rdata_a, 8'hA5);
        chk("s1_rvalid_b", bus.rvalid_b, 1'b0);

        // Both streaming reads after a reset: strict A,B alternation
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        cmd_a(1'b0, 8'h10, 8'h00);
        cmd_b(1'b0, 8'h20, 8'h00);
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            chk("alt_gnt_a", bus.gnt_a, (i % 2 == 0) ? 1'b1 : 1'b0);
            chk("alt_gnt_b", bus.gnt_b, (i % 2 == 1) ? 1'b1 : 1'b0);
            step();
        end
        idle();

        // Write B 0xFF = 0x3C, read A 0xFF on the next cycle
        step();
        cmd_b(1'b1, 8'hFF, 8'h3C);
        @(negedge clock); chk("raw_gnt_b", bus.gnt_b, 1'b1);
        step();
        bus.req_b = 1'b0;
        cmd_a(1'b0, 8'hFF, 8'h00);
        @(negedge clock); chk("raw_gnt_a", bus.gnt_a, 1'b1);
        step();
        idle();
        step();
        @(negedge clock);
        chk("raw_rvalid_a", bus.rvalid_a, 1'b1);
        chk("raw_rdata_a", bus.rdata_a, 8'h3C);

        // Hold raised while A streams reads
        step();
        cmd_a(1'b0, 8'h10, 8'h00);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock); chk("hold_pre_gnt_a", bus.gnt_a, 1'b1);
            step();
        end
        bus.hold = 1'b1;
        @(negedge clock);
        chk("hold_gnt_a_0", bus.gnt_a, 1'b0);
        chk("hold_rvalid_0", bus.rvalid_a, 1'b1);
        step();
        @(negedge clock);
        chk("hold_gnt_a_1", bus.gnt_a, 1'b0);
        chk("hold_rvalid_1", bus.rvalid_a, 1'b1);
        step();
        @(negedge clock); chk("hold_rvalid_2", bus.rvalid_a, 1'b0);
        step();
        bus.hold = 1'b0;
        @(negedge clock); chk("hold_resume_gnt_a", bus.gnt_a, 1'b1);
        step();
        idle();

        // Reset one cycle after a read grant
        step();
        cmd_a(1'b0, 8'h10, 8'h00);
        @(negedge clock); chk("rstmid_gnt_a", bus.gnt_a, 1'b1);
        step();
        idle();
        reset = 1'b1;
        step();
        reset = 1'b0;
        cmd_a(1'b0, 8'h10, 8'h00);
        cmd_b(1'b0, 8'h20, 8'h00);
        @(negedge clock);
        chk("rstmid_rvalid_a", bus.rvalid_a, 1'b0);
        chk("rstmid_mem_cs", bus.mem_cs, 1'b0);
        chk("rstmid_gnt_a", bus.gnt_a, 1'b1);
        chk("rstmid_gnt_b", bus.gnt_b, 1'b0);
        step();
        idle();

        // B alone, four back-to-back commands
        step();
        for (int i = 0; i < 4; i++) begin
            cmd_b((i % 2 == 1) ? 1'b1 : 1'b0, 8'(8'h30 + i), 8'(8'h70 + i));
            @(negedge clock);
            chk("bonly_gnt_b", bus.gnt_b, 1'b1);
            chk("bonly_rd_wr_excl", bus.mem_rd & bus.mem_wr, 1'b0);
            step();
        end
        idle();
        step();

        // Randomized traffic with occasional hold and reset
        ga_seen = 1'b1;
        gb_seen = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            if (!bus.req_a || ga_seen) begin
                bus.req_a   = ($urandom_range(0, 3) != 0);
                bus.we_a    = 1'($urandom_range(0, 1));
                bus.addr_a  = rand_addr();
                bus.wdata_a = 8'($urandom);
            end
            if (!bus.req_b || gb_seen) begin
                bus.req_b   = ($urandom_range(0, 3) != 0);
                bus.we_b    = 1'($urandom_range(0, 1));
                bus.addr_b  = rand_addr();
                bus.wdata_b = 8'($urandom);
            end
            bus.hold = ($urandom_range(0, 9) == 0);
            reset    = ($urandom_range(0, 63) == 0);
            @(negedge clock);
            ga_seen = bus.gnt_a;
            gb_seen = bus.gnt_b;
            step();
        end
        idle();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sram_rr_arbiter.md
Name: sram_rr_arbiter

Overview:
- Shares one 8x256 single-port synchronous SRAM between two requesters, A and B.
- Accepts at most one command per cycle and uses round-robin priority.
- Drives the SRAM chip-select, read and write strobes from registers.
- Returns read data to the requester that issued the read, with a fixed latency.
- Sits between two bus masters (for example, a CPU port and a DMA port) and the SRAM macro.

Parameters:
- ADDR_WD, 8, address width; must match the SRAM.
- DATA_WD, 8, data width; must match the SRAM.

Ports:
- clock  in  1  single clock; all logic is on the rising edge
- reset  in  1  synchronous, active-high reset
- hold  in  1  when 1, no grants are issued; in-flight operations complete
- req_a  in  1  requester A has a valid command
- we_a  in  1  A command type: 1 = write, 0 = read
- addr_a  in  ADDR_WD  A address
- wdata_a  in  DATA_WD  A write data
- gnt_a  out  1  A command accepted this cycle
- rvalid_a  out  1  A read data valid
- rdata_a  out  DATA_WD  A read data
- req_b, we_b, addr_b, wdata_b, gnt_b, rvalid_b, rdata_b: same as A, for requester B
- mem_addr  out  ADDR_WD  to SRAM addrLine
- mem_wdata  out  DATA_WD  to SRAM inDataLine
- mem_cs  out  1  to SRAM chipSel
- mem_rd  out  1  to SRAM readData
- mem_wr  out  1  to SRAM writeData
- mem_rdata  in  DATA_WD  from SRAM outDataLine (registered inside the SRAM)

Behaviour:
- Reset (clock edge with reset=1):
  - All registered outputs go to 0: mem_cs, mem_rd, mem_wr, mem_addr, mem_wdata, rvalid_a, rvalid_b.
  - Pipeline valid bits are cleared.
  - The priority pointer is set to A.
  - gnt_a and gnt_b are forced to 0 while reset=1.
- Handshake:
  - A requester holds req and its payload stable until it sees gnt high in the same cycle.
  - Transfer happens when req and gnt are both 1 at a rising edge.
  - gnt is combinational from req, hold and the priority pointer. It never depends on the requester's own gnt.
- Arbitration (stage 0, cycle N):
  - hold=1 or reset=1: no grant.
  - Only one requester has req=1: that requester is granted.
  - Both have req=1: the requester named by the pointer is granted.
  - After any grant, the pointer moves to the other requester. With no grant, the pointer is unchanged.
  - At most one grant per cycle. gnt_a and gnt_b are never both 1.
- Command stage (stage 1, cycle N+1):
  - Granted command is registered: mem_cs=1, mem_addr = granted address.
  - Read: mem_rd=1, mem_wr=0.
  - Write: mem_wr=1, mem_rd=0, mem_wdata = granted wdata.
  - Owner and read flag are registered alongside.
  - With no grant in cycle N: mem_cs=mem_rd=mem_wr=0. mem_addr and mem_wdata hold their previous values.
  - mem_rd and mem_wr are never both 1.
- Return stage (stage 2, cycle N+2):
  - The SRAM updates outDataLine at the end of N+1.
  - For a read, the owner's rvalid is 1 for exactly one cycle in N+2. rdata_x = mem_rdata in that cycle. The other requester's rvalid is 0.
  - rdata_a and rdata_b both continuously carry mem_rdata. Their content is only defined when the matching rvalid is 1.
  - Writes produce no response. The written data is visible to a read granted on the next cycle.
- Latency and throughput:
  - Read: grant at N, rvalid at N+2.
  - Throughput is one command per cycle, fully pipelined, with no bubbles between back-to-back commands.
- Boundary conditions:
  - Both requesters streaming continuously: grants strictly alternate A, B, A, B...
  - Read-after-write to the same address on consecutive grants (write at N, read at N+1): the read returns the new data.
  - hold asserted mid-stream: grants stop that cycle. Commands already granted still issue, and their rvalid still arrives.
  - Reset asserted mid-operation: all pipeline stages are flushed. No rvalid is produced for reads granted before reset. SRAM contents are not touched.
  - Address wrap: the address is passed through unchanged; 8'hFF is a legal address.

Test Plan:
- After reset, check all outputs are 0. Write A addr 8'h10 = 8'hA5, then read A addr 8'h10 → rvalid_a pulses exactly 2 cycles after the read grant with rdata_a=8'hA5, and rvalid_b stays 0.
- req_a and req_b held high together for 6 cycles, all reads → gnt sequence A,B,A,B,A,B; rvalid_a/rvalid_b alternate starting 2 cycles after the first grant; each requester gets its own address's data.
- Write B addr 8'hFF=8'h3C on cycle N, read A addr 8'hFF on cycle N+1 → rvalid_a at N+3 with rdata_a=8'h3C.
- Raise hold while A streams reads → gnt_a drops that same cycle; the 2 already-granted reads still return; lower hold → grants resume the next cycle.
- Assert reset one cycle after a read grant → no rvalid appears, mem_cs=0 after the reset edge, and the pointer is back at A: a simultaneous A/B request grants A first.
- Single requester B only, 4 consecutive commands → gnt_b=1 every cycle; mem_rd and mem_wr are never both high.
